// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, optional
// even parity, then a fixed idle gap before the next byte is taken.
module seq_frame_tx #(
    parameter int PARITY_EN = 1,
    parameter int GAP_LEN   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       serial_out,
    output logic       tx_active,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic       par, par_n;
    logic       ser_n, act_n, done_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 4'd1;
        sh_n    = sh;
        par_n   = par;
        unique case (state)
            IDLE: begin
                cnt_n = 4'd0;
                if (data_valid) begin
                    state_n = SYNC;
                    sh_n    = data_in;
                    par_n   = ^data_in;
                end
            end
            SYNC: begin
                if (cnt == 4'd3) begin
                    state_n = DATA;
                    cnt_n   = 4'd0;
                end
            end
            DATA: begin
                sh_n = {sh[6:0], 1'b0};
                if (cnt == 4'd7) begin
                    state_n = (PARITY_EN != 0) ? PARITY : GAP;
                    cnt_n   = 4'd0;
                end
            end
            PARITY: begin
                state_n = GAP;
                cnt_n   = 4'd0;
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase

        // Outputs are precomputed from the next state so they can be flopped.
        ser_n  = 1'b0;
        act_n  = 1'b0;
        done_n = 1'b0;
        unique case (state_n)
            SYNC: begin
                ser_n = ~cnt_n[0];
                act_n = 1'b1;
            end
            DATA: begin
                ser_n = sh_n[7];
                act_n = 1'b1;
            end
            PARITY: begin
                ser_n = par_n;
                act_n = 1'b1;
            end
            GAP: begin
                done_n = (cnt_n == GAP_LAST);
            end
            default: begin
                ser_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            sh         <= 8'd0;
            par        <= 1'b0;
            data_ready <= 1'b1;
            serial_out <= 1'b0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            par        <= par_n;
            data_ready <= (state_n == IDLE);
            serial_out <= ser_n;
            tx_active  <= act_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: default build and a no-parity, 1-gap build
// share one stimulus stream and are checked against a frame-queue model.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;

    logic a_ready, a_ser, a_act, a_done;
    logic b_ready, b_ser, b_act, b_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_frame_tx u_a (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (a_ready),
        .serial_out (a_ser),
        .tx_active  (a_act),
        .frame_done (a_done)
    );

    seq_frame_tx #(.PARITY_EN(0), .GAP_LEN(1)) u_b (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (b_ready),
        .serial_out (b_ser),
        .tx_active  (b_act),
        .frame_done (b_done)
    );

    // Model: per-cycle expected {serial, tx_active, frame_done} of the
    // frame in flight; an empty queue means the transmitter is idle.
    logic [2:0] qa[$];
    logic [2:0] qb[$];

    task automatic put(input bit is_b, input logic [2:0] e);
        if (is_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic push_frame(input bit is_b, input logic [7:0] d);
        int pe;
        int gl;
        pe = is_b ? 0 : 1;
        gl = is_b ? 1 : 2;
        for (int i = 0; i < 4; i++) put(is_b, {(i % 2 == 0), 1'b1, 1'b0});
        for (int i = 7; i >= 0; i--) put(is_b, {d[i], 1'b1, 1'b0});
        if (pe != 0) put(is_b, {^d, 1'b1, 1'b0});
        for (int i = 0; i < gl; i++) put(is_b, {1'b0, 1'b0, (i == gl - 1)});
    endtask

    task automatic model_step();
        if (reset) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0) void'(qa.pop_front());
            else if (data_valid) push_frame(1'b0, data_in);
            if (qb.size() > 0) void'(qb.pop_front());
            else if (data_valid) push_frame(1'b1, data_in);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [2:0] ea;
        logic [2:0] eb;
        ea = (qa.size() > 0) ? qa[0] : 3'b000;
        eb = (qb.size() > 0) ? qb[0] : 3'b000;
        chk("a_ready", 32'(a_ready), 32'(qa.size() == 0));
        chk("a_serial", 32'(a_ser), 32'(ea[2]));
        chk("a_active", 32'(a_act), 32'(ea[1]));
        chk("a_done", 32'(a_done), 32'(ea[0]));
        chk("b_ready", 32'(b_ready), 32'(qb.size() == 0));
        chk("b_serial", 32'(b_ser), 32'(eb[2]));
        chk("b_active", 32'(b_act), 32'(eb[1]));
        chk("b_done", 32'(b_done), 32'(eb[0]));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(a_ready && b_ready) && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(a_ready && b_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [14:0] ea;
        logic [12:0] eb;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [14:0] ga;
        logic [14:0] g2;
        logic [12:0] gb;
        int          da, db, acts, rdy, cnt;

        tbl[0] = '{8'hA5, 15'b1010_10100101_0_00, 13'b1010_10100101_0};
        tbl[1] = '{8'h3C, 15'b1010_00111100_0_00, 13'b1010_00111100_0};
        tbl[2] = '{8'h01, 15'b1010_00000001_1_00, 13'b1010_00000001_0};
        tbl[3] = '{8'hFF, 15'b1010_11111111_0_00, 13'b1010_11111111_0};
        tbl[4] = '{8'h80, 15'b1010_10000000_1_00, 13'b1010_10000000_0};

        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        tick();
        tick();
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_serial", 32'(a_ser), 32'd0);
        chk("rst_active", 32'(a_act), 32'd0);
        reset = 1'b0;
        tick();

        // Single frames from the table.
        foreach (tbl[t]) begin
            data_valid = 1'b1;
            data_in    = tbl[t].d;
            tick();
            data_valid = 1'b0;
            data_in    = ~tbl[t].d;
            ga = '0; gb = '0; da = 0; db = 0; acts = 0; rdy = 0;
            for (int k = 1; k <= 16; k++) begin
                if (k <= 15) begin
                    ga = {ga[13:0], a_ser};
                    if (a_ready) rdy++;
                end
                if (k <= 13) gb = {gb[11:0], b_ser};
                if (a_act) acts++;
                if (a_done && da == 0) da = k;
                if (b_done && db == 0) db = k;
                if (k == 16) chk("tbl_ready16", 32'(a_ready), 32'd1);
                if (k < 16) tick();
            end
            chk("tbl_bits_a", 32'(ga), 32'(tbl[t].ea));
            chk("tbl_bits_b", 32'(gb), 32'(tbl[t].eb));
            chk("tbl_done_a", 32'(da), 32'd15);
            chk("tbl_done_b", 32'(db), 32'd13);
            chk("tbl_active", 32'(acts), 32'd13);
            chk("tbl_busy", 32'(rdy), 32'd0);
            wait_idle();
        end

        // Back-to-back with data_valid held high.
        data_valid = 1'b1;
        data_in    = 8'h0F;
        tick();
        data_in = 8'h01;
        ga = '0; g2 = '0; rdy = 0;
        for (int k = 1; k <= 31; k++) begin
            if (k <= 15) begin
                ga = {ga[13:0], a_ser};
                if (a_ready) rdy++;
            end
            if (k == 16) chk("b2b_ready16", 32'(a_ready), 32'd1);
            if (k == 17) begin
                chk("b2b_ready17", 32'(a_ready), 32'd0);
                data_valid = 1'b0;
            end
            if (k >= 17) g2 = {g2[13:0], a_ser};
            tick();
        end
        chk("b2b_frame1", 32'(ga), 32'(15'b1010_00001111_0_00));
        chk("b2b_frame2", 32'(g2), 32'(15'b1010_00000001_1_00));
        chk("b2b_busy", 32'(rdy), 32'd0);
        wait_idle();

        // Reset during data bit 3 of 0xFF.
        data_valid = 1'b1;
        data_in    = 8'hFF;
        tick();
        data_valid = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        chk("mid_bit3", 32'(a_ser), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_serial", 32'(a_ser), 32'd0);
        chk("mid_ready", 32'(a_ready), 32'd1);
        reset = 1'b0;
        da = 0;
        for (int k = 0; k < 20; k++) begin
            if (a_done || b_done || a_act) da++;
            tick();
        end
        chk("mid_nodone", 32'(da), 32'd0);

        // data_valid pulse and data_in changes inside a frame.
        data_valid = 1'b1;
        data_in    = 8'h5A;
        tick();
        data_valid = 1'b0;
        data_in    = 8'h00;
        ga = '0; rdy = 0; acts = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 15) ga = {ga[13:0], a_ser};
            if (k >= 16 && a_ready) rdy++;
            if (k >= 16 && a_act) acts++;
            if (k == 3) begin
                data_valid = 1'b1;
                data_in    = 8'hC3;
            end
            if (k == 4) begin
                data_valid = 1'b0;
                data_in    = 8'h99;
            end
            tick();
        end
        chk("ign_bits", 32'(ga), 32'(15'b1010_01011010_0_00));
        chk("ign_ready", 32'(rdy), 32'd5);
        chk("ign_noextra", 32'(acts), 32'd0);

        // Reset and accept on the same edge.
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'h81;
        tick();
        reset      = 1'b0;
        data_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (a_ser || a_act || b_ser || b_act) cnt++;
            tick();
        end
        chk("rst_accept", 32'(cnt), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            data_valid = ($urandom_range(0, 2) != 0);
            data_in    = 8'($urandom);
            tick();
        end
        reset      = 1'b0;
        data_valid = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
